// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, UART FSM state encoding and parity helper.
package mmio_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with (log2(DEPTH)+1)-bit wrapping pointers; full/empty are
// derived from the pointer MSB compare. A push while full is accepted only
// when a pop happens on the same edge.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  import mmio_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s, do_pop_s;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign dout      = mem_q[rd_q[AW-1:0]];

  // Pointer and storage update; storage cleared on reset so dout is defined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter. Stores to TXDATA queue a byte; STATUS
// reports {overflow, busy, fifo_empty, fifo_full}. Serial 8N1 framing by
// default; defining UART_PARITY_EN adds an even-parity bit after the data.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;

  logic       hit_data_s, hit_status_s, wr_data_s, wr_status_s;
  logic       fifo_full_s, fifo_empty_s, pop_s, push_ok_s;
  logic [7:0] fifo_dout_s;
  logic       baud_last_s;
  logic       unused_wd_s;

  assign hit_data_s   = (A == (BASE_ADDR + TXDATA_OFS));
  assign hit_status_s = (A == (BASE_ADDR + STATUS_OFS));
  assign sel          = hit_data_s | hit_status_s;
  assign wr_data_s    = WE & hit_data_s;
  assign wr_status_s  = WE & hit_status_s;
  assign push_ok_s    = wr_data_s & (~fifo_full_s | pop_s);
  assign baud_last_s  = (baud_q == BAUD_LAST);
  assign busy         = (state_q != S_IDLE) | ~fifo_empty_s;
  assign tx           = tx_q;
  assign unused_wd_s  = ^WD[31:8];

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data_s),
    .pop   (pop_s),
    .din   (WD[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // STATUS read mux; TXDATA and unmapped addresses read as zero.
  always_comb begin
    RD = 32'd0;
    if (hit_status_s) begin
      RD[ST_OVF_BIT]   = ovf_q;
      RD[ST_BUSY_BIT]  = busy;
      RD[ST_EMPTY_BIT] = fifo_empty_s;
      RD[ST_FULL_BIT]  = fifo_full_s;
    end else begin
      RD = 32'd0;
    end
  end

  // Sticky overflow: a dropped byte sets it and wins over a same-edge clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_data_s && !push_ok_s) begin
      ovf_d = 1'b1;
    end else if (wr_status_s && WD[ST_OVF_BIT]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Serial FSM next state: shift register stays intact, bit counter indexes it.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_dout_s;
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end else begin
          tx_d    = 1'b1;
        end
      end
      S_START: begin
        if (baud_last_s) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      S_DATA: begin
        if (baud_last_s) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_d    = even_parity(shift_q);
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_last_s) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d  = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
`endif
      S_STOP: begin
        if (baud_last_s) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d  = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight frame and idles the line high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4,
// BASE_ADDR=32'h100. Honours UART_PARITY_EN when defined for the build.
module tb_mmio_uart_tx;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WE  = 1'b0;
  logic [31:0] A   = 32'd0;
  logic [31:0] WD  = 32'd0;
  logic [31:0] RD;
  logic        sel, tx, busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  mmio_uart_tx #(.BASE_ADDR(32'h100), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .WE(WE), .A(A), .WD(WD),
    .RD(RD), .sel(sel), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Store one word; called and returning at posedge+1.
  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    WE = 1'b1; A = addr; WD = data;
    tick();
    WE = 1'b0; A = 32'd0; WD = 32'd0;
  endtask

  task automatic status_is(input string tag, input logic [31:0] exp);
    A = 32'h104;
    #1;
    check_vec(tag, RD, exp);
    A = 32'd0;
  endtask

  // Cycle-exact frame check, starting right after the TXDATA store edge.
  task automatic frame_check(input logic [7:0] b);
    logic exp_bit;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (k < CPB) exp_bit = 1'b0;
      else if (k < 9 * CPB) exp_bit = b[(k / CPB) - 1];
      else if (PAR && k < 10 * CPB) exp_bit = ^b;
      else exp_bit = 1'b1;
      check_vec($sformatf("frame_%h_c%0d", b, k), {31'd0, tx}, {31'd0, exp_bit});
    end
    check_vec("busy_end_of_frame", {31'd0, busy}, 32'd1);
    tick();
    check_vec("busy_clear", {31'd0, busy}, 32'd0);
  endtask

  // Mid-bit sampling receiver with a bounded wait for the start bit.
  task automatic rx_byte(output logic [7:0] b);
    int n = 0;
    b = 8'd0;
    while (tx !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check_vec("rx_start_seen", {31'd0, (n < 200)}, 32'd1);
    if (n < 200) begin
      tick(); tick();
      check_vec("rx_start_mid", {31'd0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) tick();
        b[i] = tx;
      end
      if (PAR) begin
        repeat (CPB) tick();
        check_vec("rx_parity", {31'd0, tx}, {31'd0, ^b});
      end
      repeat (CPB) tick();
      check_vec("rx_stop", {31'd0, tx}, 32'd1);
    end
  endtask

  initial begin
    logic [7:0] rb;

    // 1 Reset
    repeat (10) tick();
    check_vec("rst_tx", {31'd0, tx}, 32'd1);
    check_vec("rst_busy", {31'd0, busy}, 32'd0);
    status_is("rst_status", 32'h2);
    rst = 1'b1;
    tick();
    sw(32'h100, 32'h0000_00AA);
    tick(); tick();
    check_vec("mid_frame_tx_low", {31'd0, tx}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check_vec("async_rst_tx", {31'd0, tx}, 32'd1);
    check_vec("async_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    #2 rst = 1'b1;
    tick();
    status_is("post_rst_status", 32'h2);

    // 2 Single byte, exact timing
    sw(32'hFFFF_FF55 & 32'h0 | 32'h100, 32'hFFFF_FF55);
    frame_check(8'h55);

    // 3 Fill: six back-to-back stores, sixth dropped
    fork
      begin
        for (int i = 1; i <= 6; i++) sw(32'h100, 32'(i));
        status_is("fill_status", 32'hD);
      end
      begin
        for (int i = 1; i <= 5; i++) begin
          rx_byte(rb);
          check_vec($sformatf("fill_rx%0d", i), {24'd0, rb}, 32'(i));
        end
      end
    join
    repeat (2 * CPB) tick();
    check_vec("fill_no_sixth", {31'd0, tx}, 32'd1);
    status_is("fill_drained", 32'hA);

    // 4 Overflow clear
    sw(32'h104, 32'h0);
    status_is("ovf_keep", 32'hA);
    sw(32'h104, 32'h8);
    status_is("ovf_clear", 32'h2);
    sw(32'h104, 32'h0);
    status_is("ovf_stay_clear", 32'h2);

    // 5 Decode
    WE = 1'b1; A = 32'h108; WD = 32'h41;
    #1;
    check_vec("dec_sel_108", {31'd0, sel}, 32'd0);
    check_vec("dec_rd_108", RD, 32'd0);
    tick();
    WE = 1'b0; A = 32'h0FC;
    #1;
    check_vec("dec_sel_0fc", {31'd0, sel}, 32'd0);
    check_vec("dec_rd_0fc", RD, 32'd0);
    A = 32'h100;
    #1;
    check_vec("dec_sel_txdata", {31'd0, sel}, 32'd1);
    check_vec("dec_rd_txdata", RD, 32'd0);
    A = 32'd0;
    repeat (3) tick();
    check_vec("dec_tx_idle", {31'd0, tx}, 32'd1);
    status_is("dec_status", 32'h2);

    // 6 Byte 8'h07 (parity bit 1 when parity is built in)
    sw(32'h100, 32'h07);
    frame_check(8'h07);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
